// File: rtl/pdp_pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdp_pool_pkg
//  Description : Shared encodings for the PDP 1D pooling engine: pooling
//                operation codes, control states and history depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package pdp_pool_pkg;

   localparam int HIST_DEPTH = 8;

   typedef enum logic [1:0] {
      POOL_SUM = 2'd0,
      POOL_MAX = 2'd1,
      POOL_MIN = 2'd2
   } pool_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } pool_state_e;

endpackage
`default_nettype wire

// File: rtl/pdp_pool1d_lane_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : pdp_pool1d_lane_reduce
//  Description : Combinational reduction of one channel lane over the window
//                entries. Entries flagged invalid are padding: they add
//                pad_value in sum mode and are skipped in max/min mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdp_pool1d_lane_reduce
   import pdp_pool_pkg::*;
#(
   parameter int DW     = 8,
   parameter int OW_EXT = 6
) (
   input  logic [1:0]               pool_type,
   input  logic [HIST_DEPTH*DW-1:0] ent,
   input  logic [HIST_DEPTH-1:0]    ent_valid,
   input  logic [2:0]               pad_cnt,
   input  logic [DW+OW_EXT-1:0]     pad_value,
   output logic [DW+OW_EXT-1:0]     result
);

   localparam int EW = DW + OW_EXT;

   logic signed [EW-1:0] w_ext [HIST_DEPTH];
   logic signed [EW-1:0] w_max;
   logic signed [EW-1:0] w_min;
   logic        [EW-1:0] w_sum;
   logic        [EW-1:0] w_pad_term;
   logic                 w_have;

   // Sign-extend entries, then form sum, max and min in one pass
   always_comb begin
      w_max  = '0;
      w_min  = '0;
      w_have = 1'b0;
      // pad_value * pad_cnt via shift-add (pad_cnt is 0..7)
      w_pad_term = (pad_cnt[0] ? pad_value : '0)
                 + (pad_cnt[1] ? {pad_value[EW-2:0], 1'b0} : '0)
                 + (pad_cnt[2] ? {pad_value[EW-3:0], 2'b0} : '0);
      w_sum = w_pad_term;
      for (int i = 0; i < HIST_DEPTH; i++) begin
         w_ext[i] = {{OW_EXT{ent[i*DW+DW-1]}}, ent[i*DW +: DW]};
         if (ent_valid[i]) begin
            w_sum = w_sum + w_ext[i];
            if (!w_have || (w_ext[i] > w_max)) w_max = w_ext[i];
            if (!w_have || (w_ext[i] < w_min)) w_min = w_ext[i];
            w_have = 1'b1;
         end
      end
   end

   // Select the requested operation; the reserved code falls back to sum
   always_comb begin
      case (pool_type)
         POOL_MAX: result = w_max;
         POOL_MIN: result = w_min;
         default:  result = w_sum;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pdp_pool1d_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pdp_pool1d_engine
//  Description : Horizontal pooling over a stream of multi-lane beats with
//                configurable kernel, stride, left pad and line count. One
//                pooled beat per output position, single output slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdp_pool1d_engine
   import pdp_pool_pkg::*;
#(
   parameter int THROUGHPUT = 1,
   parameter int DW         = 8,
   parameter int OW_EXT     = 6
) (
   input  logic                             nvdla_core_clk,
   input  logic                             nvdla_core_rstn,
   input  logic                             cfg_op_en,
   input  logic [1:0]                       cfg_pool_type,
   input  logic [2:0]                       cfg_kernel_w,
   input  logic [2:0]                       cfg_stride_w,
   input  logic [2:0]                       cfg_pad_left,
   input  logic [12:0]                      cfg_in_width,
   input  logic [12:0]                      cfg_out_width,
   input  logic [12:0]                      cfg_lines,
   input  logic [DW+OW_EXT-1:0]             cfg_pad_value,
   input  logic [THROUGHPUT*DW-1:0]         in_pd,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [THROUGHPUT*(DW+OW_EXT)-1:0] out_pd,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             op_done
);

   localparam int EW = DW + OW_EXT;

   pool_state_e                r_state, w_state_nxt;
   logic [1:0]                 r_pool_type;
   logic [2:0]                 r_k, r_s, r_pl;          // K-1, S-1, PL
   logic [12:0]                r_w, r_ow, r_lines;      // W-1, OW-1, L-1
   logic [EW-1:0]              r_pad_value;
   logic [12:0]                r_line, r_x;             // line index, next input position
   logic [13:0]                r_out_cnt;               // outputs loaded in this line
   logic signed [16:0]         r_win_base;              // b of the next output window
   logic [THROUGHPUT*DW-1:0]   r_hist [HIST_DEPTH];     // [0] = most recent beat
   logic                       r_out_valid;
   logic [THROUGHPUT*EW-1:0]   r_out_pd;

   logic                       w_slot_free, w_more, w_last_out, w_accept;
   logic                       w_load, w_line_end, w_op_start;
   logic signed [16:0]         w_x_s, w_win_end, w_top;
   logic signed [16:0]         w_pos [HIST_DEPTH];
   logic [HIST_DEPTH-1:0]      w_valid;
   logic [2:0]                 w_pad_cnt;
   logic [THROUGHPUT*EW-1:0]   w_red;

   assign w_slot_free = ~r_out_valid | out_ready;
   assign w_more      = (r_out_cnt <= {1'b0, r_ow});
   assign w_last_out  = (r_out_cnt == {1'b0, r_ow});
   assign w_x_s       = $signed({4'b0, r_x});
   assign w_win_end   = r_win_base + $signed({14'b0, r_k});
   assign in_ready    = (r_state == RUN) & w_slot_free;
   assign w_accept    = in_valid & in_ready;
   assign out_valid   = r_out_valid;
   assign out_pd      = r_out_pd;
   assign op_done     = (r_state == DONE) & ~r_out_valid;

   // Control state register
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) r_state <= IDLE;
      else                  r_state <= w_state_nxt;
   end

   // Next state, window completion and line-end decisions
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_line_end  = 1'b0;
      w_op_start  = 1'b0;
      case (r_state)
         IDLE: begin
            if (cfg_op_en) begin
               w_op_start  = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_accept) begin
               w_load = w_more && (w_x_s == w_win_end);
               if (r_x == r_w) begin
                  if (!w_more || (w_load && w_last_out)) w_line_end  = 1'b1;
                  else                                   w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_slot_free) begin
               w_load     = 1'b1;
               w_line_end = w_last_out;
            end
         end
         default: begin
            if (!r_out_valid) w_state_nxt = IDLE;
         end
      endcase
      if (w_line_end) w_state_nxt = (r_line == r_lines) ? DONE : RUN;
   end

   // Window membership of each entry; entry i sits at position top-i
   always_comb begin
      w_top     = (r_state == DRAIN) ? $signed({4'b0, r_w}) : w_x_s;
      w_pad_cnt = 3'd0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
         w_pos[i]   = w_top - 17'(i);
         w_valid[i] = (w_pos[i] >= r_win_base) && (w_pos[i] >= 17'sd0);
         if ((i <= int'(r_k)) && !w_valid[i]) w_pad_cnt = w_pad_cnt + 3'd1;
      end
   end

   // Per-lane window entries: in RUN the incoming beat closes the window
   for (genvar l = 0; l < THROUGHPUT; l++) begin : g_lane
      logic [HIST_DEPTH*DW-1:0] w_lane_ent;

      // Gather this lane's slice of the window
      always_comb begin
         w_lane_ent[DW-1:0] = (r_state == DRAIN) ? r_hist[0][l*DW +: DW] : in_pd[l*DW +: DW];
         for (int i = 1; i < HIST_DEPTH; i++) begin
            w_lane_ent[i*DW +: DW] = (r_state == DRAIN) ? r_hist[i][l*DW +: DW]
                                                        : r_hist[i-1][l*DW +: DW];
         end
      end

      pdp_pool1d_lane_reduce #(.DW(DW), .OW_EXT(OW_EXT)) u_reduce (
         .pool_type (r_pool_type),
         .ent       (w_lane_ent),
         .ent_valid (w_valid),
         .pad_cnt   (w_pad_cnt),
         .pad_value (r_pad_value),
         .result    (w_red[l*EW +: EW])
      );
   end

   // Configuration capture, position/window counters and beat history
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_pool_type <= '0;
         r_k         <= '0;
         r_s         <= '0;
         r_pl        <= '0;
         r_w         <= '0;
         r_ow        <= '0;
         r_lines     <= '0;
         r_pad_value <= '0;
         r_line      <= '0;
         r_x         <= '0;
         r_out_cnt   <= '0;
         r_win_base  <= '0;
         for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      end else if (w_op_start) begin
         r_pool_type <= cfg_pool_type;
         r_k         <= cfg_kernel_w;
         r_s         <= cfg_stride_w;
         r_pl        <= cfg_pad_left;
         r_w         <= cfg_in_width;
         r_ow        <= cfg_out_width;
         r_lines     <= cfg_lines;
         r_pad_value <= cfg_pad_value;
         r_line      <= '0;
         r_x         <= '0;
         r_out_cnt   <= '0;
         r_win_base  <= -$signed({14'b0, cfg_pad_left});
         for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      end else begin
         if (w_accept) begin
            r_hist[0] <= in_pd;
            for (int i = 1; i < HIST_DEPTH; i++) r_hist[i] <= r_hist[i-1];
            r_x <= r_x + 13'd1;
         end
         if (w_load) begin
            r_out_cnt  <= r_out_cnt + 14'd1;
            r_win_base <= r_win_base + $signed({14'b0, r_s}) + 17'sd1;
         end
         // A new line starts from a clean history so no window spans lines
         if (w_line_end) begin
            r_line     <= r_line + 13'd1;
            r_x        <= '0;
            r_out_cnt  <= '0;
            r_win_base <= -$signed({14'b0, r_pl});
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
         end
      end
   end

   // Single output slot; holds its value until accepted downstream
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_out_valid <= 1'b0;
         r_out_pd    <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_pd    <= w_red;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: doc/pdp_pool1d_engine.md
Name: pdp_pool1d_engine

Overview:
- Parametrised horizontal (1D) pooling engine for the PDP datapath. It is the successor of the fixed single-lane cal1d stage.
- Consumes a stream of input beats. Each beat holds THROUGHPUT channel lanes at one width position.
- Produces one pooled beat per output position. Modes: max, min or sum, with configurable kernel, stride and left padding.
- Feeds the vertical (2D) pooling stage through a valid/ready handshake.

Parameters:
- THROUGHPUT, 1, number of independent channel lanes per beat.
- DW, 8, signed input element width.
- OW_EXT, 6, guard bits added to each output element (output element width is DW+OW_EXT).

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- cfg_op_en  in  1  single-cycle pulse that starts an operation.
- cfg_pool_type  in  2  0=sum, 1=max, 2=min; 3 is reserved and treated as sum.
- cfg_kernel_w  in  3  kernel width K minus 1.
- cfg_stride_w  in  3  stride S minus 1.
- cfg_pad_left  in  3  left pad count PL; must satisfy PL < K.
- cfg_in_width  in  13  input line width W minus 1.
- cfg_out_width  in  13  output line width OW minus 1.
- cfg_lines  in  13  number of lines L minus 1.
- cfg_pad_value  in  DW+OW_EXT  signed pad value, used only in sum mode.
- in_pd  in  THROUGHPUT*DW  input beat, lane i in bits [i*DW +: DW].
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted.
- out_pd  out  THROUGHPUT*(DW+OW_EXT)  pooled beat, one element per lane.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- op_done  out  1  one-cycle pulse after the last output beat of line L-1 is accepted.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pd=0, op_done=0. State IDLE; all counters and history entries cleared.
- Configuration is sampled on cfg_op_en and held for the whole operation.
- State machine:
  - IDLE: on cfg_op_en go to RUN.
  - RUN: accepts input beats. After the beat at position W-1 is accepted, go to DRAIN if output windows remain, otherwise finish the line.
  - DRAIN: emits the remaining right-edge windows, one per accepted output slot. No input is consumed.
  - Line end: when output OW-1 of a line is loaded, either increment the line counter and return to RUN, or go to DONE on the last line.
  - DONE: waits until out_valid drops, pulses op_done, returns to IDLE.
  - cfg_op_en outside IDLE is ignored.
- History buffer: the last 8 accepted beats (shift register) plus the current input position x.
- Output j covers window positions b..b+K-1, where b = j*S - PL.
- Output j is computed when the beat at position b+K-1 is accepted (RUN). If b+K-1 > W-1, it is computed in DRAIN once input is exhausted.
- Window positions outside [0, W-1] are padding.
  - Sum mode: each padding position contributes cfg_pad_value. Compute as pad_value times the pad count (0..7) using shift-add.
  - Max/min modes: padding is ignored. A window containing only padding cannot occur because PL < K.
- Arithmetic:
  - Inputs are sign-extended to DW+OW_EXT before reduction.
  - Sum wraps modulo 2^(DW+OW_EXT).
  - Max/min compare as signed values.
- Output register: a single slot.
  - The output is loaded one cycle after the completing beat is accepted, i.e. latency 1.
  - in_ready = (state==RUN) & (~out_valid | out_ready).
  - A new output may load in the same cycle that the previous one is accepted.
  - out_pd stays stable while out_valid=1 and out_ready=0.
- Inputs at positions that belong to no window (stride S > K) are accepted and discarded.
- Line boundary: history and the position counter clear at the start of each line, so no window spans two lines.
- Asynchronous reset mid-operation: all state is lost, outputs return to reset values, and no op_done is produced.

Decomposition:
- Package pdp_pool_pkg holds:
  - pool_type encodings (SUM, MAX, MIN);
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the history depth constant HIST_DEPTH=8.
- One sub-module, pdp_pool1d_lane_reduce: combinational per-lane reduction over 8 history entries, a validity mask and the pad count. It is instantiated THROUGHPUT times.

Test Plan:
- Max: W=4, K=2, S=2, PL=0, OW=2, inputs 3,7,-2,5 -> outputs 7,5; op_done one cycle after the second output is accepted.
- Sum with padding: W=4, K=3, S=1, PL=1, OW=4, pad=1, inputs 1,2,3,4 -> outputs 4,6,9,8; the last output is produced in DRAIN.
- Min with padding ignored: W=5, K=3, S=2, PL=1, OW=3, inputs 5,-1,4,2,0 -> outputs -1,-1,0.
- Backpressure: hold out_ready=0 for 5 cycles mid-line.
  - in_ready drops while the output slot is full.
  - out_pd is stable throughout.
  - Released stream is identical to the no-stall run.
- THROUGHPUT=4, max mode, L=2 lines, each lane with distinct data -> per-lane results independent and line 2 unaffected by line 1 history; exactly one op_done.
- Assert nvdla_core_rstn low mid-line -> out_valid=0 and in_ready=0 immediately. A fresh cfg_op_en afterwards gives correct results with no stale history.
